univ_shift_reg: RTL

Parametrised universal shift register, successor to the single-bit serial-in/serial-out register. It supports hold, shift-right, shift-left and parallel-load modes over a WIDTH-bit word, and exposes serial and parallel outputs at once, so a single instance covers the SISO, SIPO, PISO and PIPO cases. A shift counter flags each completed serial word so that serialiser/deserialiser logic can frame data without an external counter.

---
 rtl/univ_shreg_pkg.sv | 16 +
 rtl/shreg_bit_cnt.sv | 38 +++
 rtl/univ_shift_reg.sv | 95 +++++++++
 3 files changed

// File: rtl/univ_shreg_pkg.sv
// Shared types and helpers for the universal shift register.
// Optional feature macro: UNIV_SHREG_PARITY_EN (see univ_shift_reg.sv).
package univ_shreg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } shreg_mode_t;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shreg_bit_cnt.sv
// Modulo-WIDTH shift counter with a one-cycle wrap pulse
// that frames each completed serial word.
module shreg_bit_cnt
    import univ_shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inc,
    input  logic                       clr,
    output logic [cnt_w(WIDTH)-1:0]    count,
    output logic                       wrap_pulse
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic at_last;

    assign at_last = (count == LAST);

    // wrap_pulse is rewritten every edge so it lasts exactly one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= inc && !clr && at_last;
            if (clr) begin
                count <= '0;
            end else if (inc) begin
                count <= at_last ? '0 : count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load.
// Define UNIV_SHREG_PARITY_EN to generate the registered even-parity output.
module univ_shift_reg
    import univ_shreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic                    din_r,
    input  logic                    din_l,
    input  logic [WIDTH-1:0]        pin,
    output logic [WIDTH-1:0]        pout,
    output logic                    dout_r,
    output logic                    dout_l,
    output logic [cnt_w(WIDTH)-1:0] count,
    output logic                    word_done,
    output logic                    parity
);

    shreg_mode_t      mode_q;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             inc;
    logic             clr;

    assign mode_q = shreg_mode_t'(mode);

    always_comb begin
        q_next = q;
        inc    = 1'b0;
        clr    = 1'b0;
        if (en) begin
            unique case (mode_q)
                MODE_HOLD: q_next = q;
                MODE_SHR: begin
                    q_next = {din_r, q[WIDTH-1:1]};
                    inc    = 1'b1;
                end
                MODE_SHL: begin
                    q_next = {q[WIDTH-2:0], din_l};
                    inc    = 1'b1;
                end
                MODE_LOAD: begin
                    q_next = pin;
                    clr    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            q <= q_next;
        end
    end

    shreg_bit_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc),
        .clr       (clr),
        .count     (count),
        .wrap_pulse(word_done)
    );

`ifdef UNIV_SHREG_PARITY_EN
    logic par_q;

    // computed from q_next so parity changes on the same edge as q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= ^RESET_VAL;
        end else begin
            par_q <= ^q_next;
        end
    end

    assign parity = par_q;
`else
    assign parity = 1'b0;
`endif

    assign pout   = q;
    assign dout_r = q[0];
    assign dout_l = q[WIDTH-1];

endmodule
